// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared opcodes, flag bit positions and FSM encoding
package alu_sequencer_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// seq_regfile: general register file with operand/debug reads and one write port
module seq_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     a_sel,
    input  logic [AW-1:0]     b_sel,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    input  logic [AW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_sel,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    assign a_data   = regs[a_sel];
    assign b_data   = regs[b_sel];
    assign dbg_data = regs[dbg_sel];

    // single synchronous write port, whole file cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_sel] <= wr_data;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-cycle control unit that drives an external ALU and commits results
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs,
    input  logic              instr_use_imm,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_sign,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        flags,
    input  logic [AW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] res_h;
    logic [3:0]        flags_h;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              accept;

    assign accept = instr_valid && instr_ready;

    seq_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_sel    (instr_rd),
        .b_sel    (instr_rs),
        .a_data   (rf_a),
        .b_data   (rf_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .wr_en    (done),
        .wr_sel   (rd_q),
        .wr_data  (res_h)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next state and handshake/pulse outputs
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                state_nxt   = accept ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                done      = is_legal(op_q);
                illegal   = !is_legal(op_q);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // operand launch at accept, ALU capture in EXEC, flag commit in WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            rd_q       <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_h      <= '0;
            flags_h    <= '0;
            flags      <= '0;
        end else begin
            if (accept) begin
                op_q       <= instr_op;
                rd_q       <= instr_rd;
                alu_opcode <= instr_op;
                alu_a      <= rf_a;
                alu_b      <= instr_use_imm ? instr_imm : rf_b;
            end
            if (state == ST_EXEC) begin
                res_h           <= alu_res;
                flags_h[FLAG_C] <= alu_carry;
                flags_h[FLAG_Z] <= alu_zero;
                flags_h[FLAG_V] <= alu_overflow;
                flags_h[FLAG_S] <= alu_sign;
            end
            if (done) flags <= flags_h;
        end
    end

endmodule
